// File: rtl/control_cmd_dispatch.sv
// Command sequencer: decodes opcode bytes, forwards payload strobes to one
// handler, and muxes that handler onto the shared frame-buffer write port.
module control_cmd_dispatch #(
  parameter int unsigned                  NUM_SUBCMDS     = 4,
  parameter logic [NUM_SUBCMDS*8-1:0]     OPCODE_MAP      = {8'h04, 8'h03, 8'h02, 8'h01},
  parameter int unsigned                  TIMEOUT_CYCLES  = 65535,
  parameter int unsigned                  BYTES_PER_PIXEL = 3,
  parameter int unsigned                  PIXEL_HEIGHT    = 16,
  parameter int unsigned                  PIXEL_WIDTH     = 32,
  localparam int unsigned RW = (PIXEL_HEIGHT    > 1) ? $clog2(PIXEL_HEIGHT)    : 1,
  localparam int unsigned CW = (PIXEL_WIDTH     > 1) ? $clog2(PIXEL_WIDTH)     : 1,
  localparam int unsigned PW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                data_in,
  input  logic                      enable,
  output logic [NUM_SUBCMDS-1:0]    sub_enable,
  output logic [NUM_SUBCMDS-1:0]    sub_abort,
  input  logic [NUM_SUBCMDS-1:0]    sub_done,
  input  logic [NUM_SUBCMDS-1:0]    sub_we,
  input  logic [NUM_SUBCMDS-1:0]    sub_as,
  input  logic [NUM_SUBCMDS*RW-1:0] sub_row,
  input  logic [NUM_SUBCMDS*CW-1:0] sub_column,
  input  logic [NUM_SUBCMDS*PW-1:0] sub_pixel,
  input  logic [NUM_SUBCMDS*8-1:0]  sub_data,
  output logic [RW-1:0]             row,
  output logic [CW-1:0]             column,
  output logic [PW-1:0]             pixel,
  output logic [7:0]                data_out,
  output logic                      ram_write_enable,
  output logic                      ram_access_start,
  output logic                      busy,
  output logic [NUM_SUBCMDS-1:0]    active_sel,
  output logic                      cmd_done,
  output logic                      err_unknown,
  output logic                      err_timeout
);

  localparam int unsigned SELW = (NUM_SUBCMDS > 1) ? $clog2(NUM_SUBCMDS) : 1;
  localparam int unsigned WDW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [SELW-1:0] sel;
  logic [WDW-1:0]  wdog;
  logic            as_prev;
  logic            as_out;

  logic            match_found;
  logic [SELW-1:0] match_idx;
  logic            sel_done;
  logic            expire;
  logic            decode_now;

  // Descending scan so the lowest matching index is the last assignment.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int unsigned i = NUM_SUBCMDS; i > 0; i--) begin
      if (data_in == OPCODE_MAP[(i-1)*8 +: 8]) begin
        match_found = 1'b1;
        match_idx   = SELW'(i - 1);
      end
    end
  end

  assign sel_done   = (state == ACTIVE) && sub_done[sel];
  assign expire     = (state == ACTIVE) && (wdog == WDW'(TIMEOUT_CYCLES)) && !sel_done;
  // A strobe in the done cycle is the next opcode, so it is decoded, not forwarded.
  assign decode_now = enable && ((state == IDLE) || sel_done);

  // Status pulses are combinational from registered state so they line up
  // with the cycle in which the triggering condition is seen.
  assign busy             = (state == ACTIVE);
  assign cmd_done         = sel_done;
  assign err_unknown      = decode_now && !match_found;
  assign err_timeout      = expire;
  assign ram_access_start = as_out;

  always_comb begin
    sub_enable       = '0;
    sub_abort        = '0;
    active_sel       = '0;
    row              = '0;
    column           = '0;
    pixel            = '0;
    data_out         = '0;
    ram_write_enable = 1'b0;
    if (state == ACTIVE) begin
      sub_enable[sel]  = enable && !sel_done;
      sub_abort[sel]   = expire;
      active_sel[sel]  = 1'b1;
      row              = sub_row[sel*RW +: RW];
      column           = sub_column[sel*CW +: CW];
      pixel            = sub_pixel[sel*PW +: PW];
      data_out         = sub_data[sel*8 +: 8];
      ram_write_enable = sub_we[sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      wdog    <= '0;
      as_prev <= 1'b0;
      as_out  <= 1'b0;
    end else begin
      if ((state == ACTIVE) && (sub_as[sel] != as_prev)) begin
        as_out  <= ~as_out;
        as_prev <= sub_as[sel];
      end
      // Resampling as_prev on selection keeps a handler switch from flipping the RAM toggle.
      if (decode_now && match_found) begin
        state   <= ACTIVE;
        sel     <= match_idx;
        as_prev <= sub_as[match_idx];
        wdog    <= '0;
      end else if (sel_done || expire) begin
        state <= IDLE;
        wdog  <= '0;
      end else if (state == ACTIVE) begin
        if (enable)
          wdog <= '0;
        else if (wdog != WDW'(TIMEOUT_CYCLES))
          wdog <= wdog + WDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Directed bench for control_cmd_dispatch: handler side is driven directly
// by the stimulus, every expectation is a hand-computed constant.
module tb_control_cmd_dispatch;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 5;
  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_in;
  logic          enable;
  logic [N-1:0]  sub_enable, sub_abort, sub_done, sub_we, sub_as;
  logic [N*RW-1:0] sub_row;
  logic [N*CW-1:0] sub_column;
  logic [N*PW-1:0] sub_pixel;
  logic [N*8-1:0]  sub_data;
  logic [RW-1:0] row;
  logic [CW-1:0] column;
  logic [PW-1:0] pixel;
  logic [7:0]    data_out;
  logic          ram_write_enable, ram_access_start, busy;
  logic [N-1:0]  active_sel;
  logic          cmd_done, err_unknown, err_timeout;

  int checks   = 0;
  int failures = 0;

  control_cmd_dispatch #(
    .NUM_SUBCMDS     (N),
    .OPCODE_MAP      ({8'h04, 8'h03, 8'h02, 8'h01}),
    .TIMEOUT_CYCLES  (16),
    .BYTES_PER_PIXEL (3),
    .PIXEL_HEIGHT    (16),
    .PIXEL_WIDTH     (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .enable           (enable),
    .sub_enable       (sub_enable),
    .sub_abort        (sub_abort),
    .sub_done         (sub_done),
    .sub_we           (sub_we),
    .sub_as           (sub_as),
    .sub_row          (sub_row),
    .sub_column       (sub_column),
    .sub_pixel        (sub_pixel),
    .sub_data         (sub_data),
    .row              (row),
    .column           (column),
    .pixel            (pixel),
    .data_out         (data_out),
    .ram_write_enable (ram_write_enable),
    .ram_access_start (ram_access_start),
    .busy             (busy),
    .active_sel       (active_sel),
    .cmd_done         (cmd_done),
    .err_unknown      (err_unknown),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; data_in = '0;
    sub_done = '0; sub_as = '0; sub_we = 4'b0101;
    sub_row = 16'h7A35;
    sub_column = '0; sub_column[0 +: CW] = 5'h11; sub_column[2*CW +: CW] = 5'h0C;
    sub_pixel = 8'b00_10_00_01;
    sub_data = 32'h44C3B2A5;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_active_sel", active_sel, 0);
    check("rst_ras", ram_access_start, 0);
    check("rst_sub_enable", sub_enable, 0);
    check("rst_row", row, 0);
    check("rst_data_out", data_out, 0);
    reset = 1'b0;

    // opcode 0x01, payload to handler 0
    @(negedge clk); enable = 1; data_in = 8'h01; #1;
    check("op_not_fwd", sub_enable, 0);
    check("op_busy_same", busy, 0);
    @(negedge clk); enable = 0; #1;
    check("h0_busy", busy, 1);
    check("h0_active_sel", active_sel, 4'b0001);
    check("h0_row", row, 4'h5);
    check("h0_column", column, 5'h11);
    check("h0_pixel", pixel, 2'b01);
    check("h0_data_out", data_out, 8'hA5);
    check("h0_we", ram_write_enable, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); enable = 1; data_in = 8'h10 + 8'(i); #1;
      check("h0_payload_fwd", sub_enable, 4'b0001);
      @(negedge clk); enable = 0; #1;
      check("h0_payload_gap", sub_enable, 0);
    end
    @(negedge clk); sub_as[0] = 1; #1;
    check("h0_as_latency", ram_access_start, 0);
    @(negedge clk); #1;
    check("h0_as_flip", ram_access_start, 1);
    @(negedge clk); sub_done[1] = 1; #1;
    check("foreign_done", cmd_done, 0);
    @(negedge clk); sub_done[1] = 0; #1;
    check("foreign_done_busy", busy, 1);
    @(negedge clk); sub_done[0] = 1; #1;
    check("h0_cmd_done", cmd_done, 1);
    @(negedge clk); sub_done[0] = 0; #1;
    check("h0_idle_busy", busy, 0);
    check("h0_idle_cmd_done", cmd_done, 0);
    check("idle_row", row, 0);
    check("idle_data_out", data_out, 0);
    check("idle_we", ram_write_enable, 0);

    // unknown opcode
    @(negedge clk); enable = 1; data_in = 8'h7F; #1;
    check("unk_err", err_unknown, 1);
    check("unk_sub_enable", sub_enable, 0);
    @(negedge clk); enable = 0; #1;
    check("unk_err_clear", err_unknown, 0);
    check("unk_busy", busy, 0);
    check("unk_active_sel", active_sel, 0);

    // back-to-back handler 0 then handler 2 via done+enable
    @(negedge clk); sub_as[2] = 1; #1;
    @(negedge clk); #1;
    check("idle_as_hold", ram_access_start, 1);
    @(negedge clk); enable = 1; data_in = 8'h01;
    @(negedge clk); enable = 0; #1;
    check("sw_h0_sel", active_sel, 4'b0001);
    @(negedge clk); sub_as[0] = 0;
    @(negedge clk); #1;
    check("sw_h0_as", ram_access_start, 0);
    @(negedge clk); sub_done[0] = 1; enable = 1; data_in = 8'h03; #1;
    check("sw_cmd_done", cmd_done, 1);
    check("sw_not_fwd", sub_enable, 0);
    @(negedge clk); sub_done[0] = 0; enable = 0; #1;
    check("sw_h2_sel", active_sel, 4'b0100);
    check("sw_no_flip", ram_access_start, 0);
    check("sw_h2_row", row, 4'hA);
    check("sw_h2_column", column, 5'h0C);
    check("sw_h2_pixel", pixel, 2'b10);
    check("sw_h2_data_out", data_out, 8'hC3);
    @(negedge clk); #1;
    check("sw_no_flip_later", ram_access_start, 0);
    @(negedge clk); sub_as[2] = 0;
    @(negedge clk); #1;
    check("sw_h2_as", ram_access_start, 1);
    @(negedge clk); sub_done[2] = 1; #1;
    check("h2_cmd_done", cmd_done, 1);
    @(negedge clk); sub_done[2] = 0; #1;
    check("h2_idle", busy, 0);

    // watchdog expiry after 16 silent cycles
    @(negedge clk); enable = 1; data_in = 8'h01;
    @(negedge clk); enable = 0; #1;
    check("wd_busy", busy, 1);
    for (int i = 1; i <= 15; i++) @(negedge clk);
    #1;
    check("wd_early", err_timeout, 0);
    @(negedge clk); #1;
    check("wd_err_timeout", err_timeout, 1);
    check("wd_sub_abort", sub_abort, 4'b0001);
    @(negedge clk); #1;
    check("wd_err_clear", err_timeout, 0);
    check("wd_abort_clear", sub_abort, 0);
    check("wd_idle", busy, 0);
    @(negedge clk); enable = 1; data_in = 8'h02;
    @(negedge clk); enable = 0; #1;
    check("wd_next_sel", active_sel, 4'b0010);
    @(negedge clk); sub_done[1] = 1; #1;
    check("wd_next_done", cmd_done, 1);
    @(negedge clk); sub_done[1] = 0;

    // reset mid-payload
    @(negedge clk); enable = 1; data_in = 8'h01;
    @(negedge clk); data_in = 8'h55; #1;
    check("rm_fwd", sub_enable, 4'b0001);
    enable = 0; reset = 1; #1;
    check("rm_busy", busy, 0);
    check("rm_active_sel", active_sel, 0);
    check("rm_row", row, 0);
    check("rm_ras", ram_access_start, 0);
    check("rm_abort", sub_abort, 0);
    @(negedge clk); reset = 0;
    @(negedge clk); enable = 1; data_in = 8'h01;
    @(negedge clk); data_in = 8'h20; #1;
    check("rm_again_fwd", sub_enable, 4'b0001);
    @(negedge clk); enable = 0; sub_done[0] = 1; #1;
    check("rm_again_done", cmd_done, 1);
    @(negedge clk); sub_done[0] = 0; #1;
    check("rm_again_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
